// File: rtl/dse_out_serializer.sv
// dse_out_serializer: buffers wide DSE endpoint records and streams them LSB-first as BEAT_WIDTH beats.
// Optional build macro DSE_OUT_HEADER_EN prefixes every record with a {16'hD5E0, 16'h0, seq} header beat.
module dse_out_serializer #(
  parameter int IN_WIDTH   = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int DEPTH      = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_enable,
  input  logic [IN_WIDTH-1:0]     in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BEAT_WIDTH-1:0]   out_data,
  output logic                    out_last,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [31:0]             drop_count,
  output logic                    busy
);

`ifdef DSE_OUT_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NBEATS = (IN_WIDTH + BEAT_WIDTH - 1) / BEAT_WIDTH;
  localparam int TOTAL  = NBEATS + HDR;
  localparam int IDX_W  = $clog2(TOTAL + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     beat_q, beat_d;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [31:0]          drop_q;
  logic [IN_WIDTH-1:0]  mem [DEPTH];
  logic [IN_WIDTH-1:0]  rd_data_q, byp_data_q, head;
  logic                 bypass_q;
  logic                 hs, last_hs, push, pop;

  logic [NBEATS*BEAT_WIDTH-1:0] head_ext;
  logic [BEAT_WIDTH-1:0]        beats [2**IDX_W];
  logic [BEAT_WIDTH-1:0]        beat_sel;
  logic [IDX_W-1:0]             data_idx;

  // The RAM read is registered; a record written into the slot being read lands via the bypass.
  assign head = bypass_q ? byp_data_q : rd_data_q;

  always_comb begin
    head_ext = '0;
    head_ext[IN_WIDTH-1:0] = head;
  end

  for (genvar gi = 0; gi < 2**IDX_W; gi++) begin : g_beat
    if (gi < NBEATS) begin : g_data
      assign beats[gi] = head_ext[gi*BEAT_WIDTH +: BEAT_WIDTH];
    end else begin : g_pad
      assign beats[gi] = '0;
    end
  end

`ifdef DSE_OUT_HEADER_EN
  logic [31:0]           seq_q;
  logic [63:0]           hdr_raw;
  logic [BEAT_WIDTH-1:0] hdr_beat;

  assign hdr_raw = {16'hD5E0, 16'h0000, seq_q};
  if (BEAT_WIDTH >= 64) begin : g_hdr_ext
    always_comb begin
      hdr_beat = '0;
      hdr_beat[63:0] = hdr_raw;
    end
  end else begin : g_hdr_trunc
    assign hdr_beat = hdr_raw[BEAT_WIDTH-1:0];
  end

  assign data_idx = beat_q - IDX_W'(1);
  assign beat_sel = (beat_q == '0) ? hdr_beat : beats[data_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      seq_q <= '0;
    end else if (hs && (beat_q == '0)) begin
      seq_q <= seq_q + 32'd1;
    end
  end
`else
  assign data_idx = beat_q;
  assign beat_sel = beats[data_idx];
`endif

  assign out_valid  = (state_q == SEND);
  assign out_last   = out_valid && (beat_q == LAST_IDX);
  assign out_data   = out_valid ? beat_sel : '0;
  assign hs         = out_valid && out_ready;
  assign last_hs    = hs && (beat_q == LAST_IDX);
  assign pop        = last_hs;
  // A full FIFO still takes a record when the head's final beat leaves in the same cycle.
  assign push       = in_enable && ((count_q < FULL) || last_hs);
  assign fifo_count = count_q;
  assign drop_count = drop_q;
  assign busy       = (count_q != '0);

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = SEND;
          beat_d  = '0;
        end
      end
      SEND: begin
        if (last_hs) begin
          beat_d = '0;
          if (count_d == '0) state_d = IDLE;
        end else if (hs) begin
          beat_d = beat_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      bypass_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      bypass_q <= push && (wr_ptr_q == rd_ptr_d);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (in_enable && !push && (drop_q != 32'hFFFF_FFFF)) drop_q <= drop_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= in_data;
    rd_data_q  <= mem[rd_ptr_d];
    byp_data_q <= in_data;
  end

endmodule

// File: tb/tb_dse_out_serializer.sv
// Randomised and directed bench for dse_out_serializer against a record-queue reference model.
`timescale 1ns/1ps
module tb_dse_out_serializer;
  localparam int IW    = 256;
  localparam int BW    = 64;
  localparam int DEPTH = 8;
  localparam int NB    = 4;
`ifdef DSE_OUT_HEADER_EN
  localparam bit HDR   = 1'b1;
`else
  localparam bit HDR   = 1'b0;
`endif
  localparam int TOTAL = NB + (HDR ? 1 : 0);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_enable = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          out_valid, out_last, busy;
  logic [BW-1:0] out_data;
  logic [3:0]    fifo_count;
  logic [31:0]   drop_count;

  always #5 clock = ~clock;

  dse_out_serializer #(.IN_WIDTH(IW), .BEAT_WIDTH(BW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_enable(in_enable), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .fifo_count(fifo_count), .drop_count(drop_count), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queued records, position within head record, drops, header sequence.
  logic [IW-1:0] mq[$];
  int            m_pos = 0;
  logic [31:0]   m_drops = '0;
  logic [31:0]   m_seq = '0;
  bit            m_prev_nonempty = 1'b0;
  bit            m_just_reset = 1'b1;
  int            rx_records = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] exp_beat(input logic [IW-1:0] rec, input int pos);
    logic [NB*BW-1:0] ext;
    int k;
    if (HDR && pos == 0) return {16'hD5E0, 16'h0000, m_seq};
    k = pos - (HDR ? 1 : 0);
    ext = '0;
    ext[IW-1:0] = rec;
    return ext[k*BW +: BW];
  endfunction

  function automatic logic [IW-1:0] rand_rec();
    logic [IW-1:0] r;
    for (int i = 0; i < IW/32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle(input bit en, input logic [IW-1:0] d, input bit rdy, input bit rst);
    bit exp_valid, hs, last_hs, accept;
    int size_before;
    in_enable = en;
    in_data   = d;
    out_ready = rdy;
    reset     = rst;
    @(negedge clock);
    exp_valid = (mq.size() > 0) && m_prev_nonempty;
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    chk("drop_count", 64'(drop_count), 64'(m_drops));
    chk("busy", 64'(busy), 64'(mq.size() > 0));
    if (exp_valid) begin
      chk("out_data", 64'(out_data), 64'(exp_beat(mq[0], m_pos)));
      chk("out_last", 64'(out_last), 64'(m_pos == TOTAL - 1));
    end
    if (m_just_reset) begin
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
    end
    @(posedge clock);
    if (rst) begin
      mq.delete();
      m_pos = 0;
      m_drops = '0;
      m_seq = '0;
      m_prev_nonempty = 1'b0;
      m_just_reset = 1'b1;
    end else begin
      m_just_reset = 1'b0;
      size_before = mq.size();
      hs = exp_valid && rdy;
      last_hs = hs && (m_pos == TOTAL - 1);
      accept = en && ((size_before < DEPTH) || last_hs);
      if (en && !accept && (m_drops != 32'hFFFF_FFFF)) m_drops = m_drops + 32'd1;
      if (hs) begin
        if (HDR && m_pos == 0) m_seq = m_seq + 32'd1;
        if (last_hs) begin
          $display("rx record %0d: %h", rx_records, mq[0]);
          rx_records++;
          void'(mq.pop_front());
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end
      if (accept) mq.push_back(d);
      m_prev_nonempty = (size_before > 0);
    end
    #1;
  endtask

  initial begin
    logic [IW-1:0] rec;
    repeat (3) @(posedge clock);
    #1;
    // Reset values
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Single record, beats 1..4 streamed back to back
    rec = {64'd4, 64'd3, 64'd2, 64'd1};
    cycle(1'b1, rec, 1'b1, 1'b0);
    repeat (8) cycle(1'b0, '0, 1'b1, 1'b0);

    // Stall mid-record for 5 cycles
    cycle(1'b1, rand_rec(), 1'b1, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);
    repeat (5) cycle(1'b0, '0, 1'b0, 1'b0);
    repeat (8) cycle(1'b0, '0, 1'b1, 1'b0);

    // Overflow: 10 pushes into a stalled FIFO
    repeat (10) cycle(1'b1, rand_rec(), 1'b0, 1'b0);
    chk("ovf_fifo_count", 64'(fifo_count), 64'd8);
    chk("ovf_drop_count", 64'(drop_count), 64'd2);
    repeat (50) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("ovf_drained", 64'(fifo_count), 64'd0);

    // Full FIFO with push on the head's last-beat handshake
    repeat (8) cycle(1'b1, rand_rec(), 1'b0, 1'b0);
    repeat (TOTAL - 1) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, rand_rec(), 1'b1, 1'b0);
    chk("full_push_count", 64'(fifo_count), 64'd8);
    chk("full_push_drops", 64'(drop_count), 64'd2);
    repeat (50) cycle(1'b0, '0, 1'b1, 1'b0);

    // Random traffic
    repeat (400) cycle($urandom_range(0, 2) == 0, rand_rec(), $urandom_range(0, 9) < 7, 1'b0);
    repeat (60) cycle(1'b0, '0, 1'b1, 1'b0);

    // Reset mid-record with 3 records queued, in_enable high during reset
    repeat (3) cycle(1'b1, rand_rec(), 1'b0, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, rand_rec(), 1'b1, 1'b1);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_count", 64'(fifo_count), 64'd0);
    chk("mid_rst_drops", 64'(drop_count), 64'd0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    // Traffic after reset
    cycle(1'b1, rand_rec(), 1'b1, 1'b0);
    cycle(1'b1, rand_rec(), 1'b1, 1'b0);
    repeat (15) cycle(1'b0, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dse_out_serializer.md
DSE_OUT_SERIALIZER -- requirements
Module: dse_out_serializer

Interface
REQ-001 SHALL provide parameter IN_WIDTH, default 256: width of one endpoint record, magic number in the MSBs.
REQ-002 SHALL provide parameter BEAT_WIDTH, default 64: width of one host-channel beat.
REQ-003 SHALL provide parameter DEPTH, default 8: record FIFO depth, power of two, at least 2.
REQ-004 SHALL derive NBEATS = ceil(IN_WIDTH/BEAT_WIDTH), default 4.
REQ-005 clock  input  1  clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_enable  input  1  record strobe from DSE endpoint; no backpressure.
REQ-008 in_data  input  IN_WIDTH  record payload, sampled when in_enable=1.
REQ-009 out_valid  output  1  beat valid toward host channel.
REQ-010 out_ready  input  1  host channel accepts beat.
REQ-011 out_data  output  BEAT_WIDTH  current beat.
REQ-012 out_last  output  1  final beat of current record.
REQ-013 fifo_count  output  clog2(DEPTH)+1  records held, including the one being sent.
REQ-014 drop_count  output  32  records dropped on overflow, saturating.
REQ-015 busy  output  1  high when fifo_count is nonzero.

Function
REQ-016 SHALL buffer records in a DEPTH-entry FIFO; push when in_enable=1 and record accepted.
REQ-017 SHALL accept a push when fifo_count<DEPTH, or when fifo_count==DEPTH and the head record's last beat handshakes in the same cycle.
REQ-018 SHALL drop an unaccepted push and increment drop_count by 1, saturating at 32'hFFFF_FFFF; FIFO contents unchanged.
REQ-019 SHALL run an FSM {IDLE, SEND}: IDLE->SEND when FIFO non-empty; SEND->IDLE on last-beat handshake with FIFO becoming empty; otherwise stay in SEND with beat index reset to 0.
REQ-020 SHALL emit beats LSB-first: beat k = in_data[k*BEAT_WIDTH +: BEAT_WIDTH]; bits above IN_WIDTH in the final beat are zero.
REQ-021 SHALL handshake a beat when out_valid && out_ready; beat index advances only on handshake; index wraps to 0 after beat NBEATS-1.
REQ-022 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-023 SHALL assert out_last only on beat NBEATS-1 (header beat never last).
REQ-024 SHALL pop the head record on its last-beat handshake; simultaneous push and pop leaves fifo_count unchanged.
REQ-025 SHALL have latency: a record pushed into an empty FIFO at edge N drives out_valid=1 with beat 0 after edge N+1; back-to-back records stream with no idle cycle when out_ready=1.
REQ-026 SHALL preserve record order; no record is duplicated or reordered.
REQ-027 SHALL keep fifo_count within 0..DEPTH at all times.

Reset
REQ-028 SHALL on reset set out_valid=0, out_last=0, out_data=0, fifo_count=0, drop_count=0, busy=0, FSM=IDLE, beat index=0, FIFO pointers=0 (and seq=0 when header is enabled).
REQ-029 SHALL, on reset asserted mid-record, discard all buffered and partly sent records with no further beats; in_enable during reset is ignored and not counted as dropped.

Configuration
REQ-030 SHALL compile a per-record header beat in when DSE_OUT_HEADER_EN is defined: header is sent before beat 0 as {16'hD5E0, 16'h0, seq[31:0]}, zero-extended or truncated to BEAT_WIDTH.
REQ-031 SHALL, with DSE_OUT_HEADER_EN, increment seq by 1 on each header handshake, wrapping modulo 2^32; each record then takes NBEATS+1 beats.
REQ-032 SHALL, without DSE_OUT_HEADER_EN, instantiate no header or seq logic and send exactly NBEATS beats per record.

Verification
REQ-033 Single record 256'h4_..._0003_0002_0001 pushed with out_ready=1 -> beats 1,2,3,4 on consecutive cycles starting one cycle after the push, out_last on beat 4.
REQ-034 out_ready=0 for 5 cycles mid-record -> out_data and out_last frozen; resumes with the next beat after out_ready=1.
REQ-035 out_ready=0, 10 pushes at DEPTH=8 -> fifo_count=8, drop_count=2; after draining, exactly 8 records are received in order.
REQ-036 FIFO full and last-beat handshake in the same cycle as a push -> push accepted, fifo_count stays 8, drop_count unchanged.
REQ-037 Reset asserted at beat 2 with 3 records queued -> next cycle out_valid=0, fifo_count=0, drop_count=0.
REQ-038 DSE_OUT_HEADER_EN defined, 3 records -> header beats carry seq 0,1,2 with upper bits 16'hD5E0, each record is 5 beats, out_last only on the 5th beat.
